// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with redirect/stall control and the IF/ID pipeline register.
// PCF is driven straight from the PC register; every other output comes from the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'hBFC00000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [31:0] FetchCount
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pcd_q, pcd_d;
    logic [XLEN-1:0] pcplus4d_q, pcplus4d_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] count_q, count_d;
    logic [XLEN-1:0] pcplus4_f;

    assign pcplus4_f = pc_q + XLEN'(4);

    // Redirect wins over stall; target is forced word-aligned.
    always_comb begin
        pc_d = pcplus4_f;
        if (PCSrcE) begin
            pc_d = {PCTargetE[31:2], 2'b00};
        end else if (StallF) begin
            pc_d = pc_q;
        end
    end

    // IF/ID register: flush beats stall; only a real load bumps the fetch counter.
    always_comb begin
        instr_d    = instr_q;
        pcd_d      = pcd_q;
        pcplus4d_d = pcplus4d_q;
        valid_d    = valid_q;
        count_d    = count_q;
        if (FlushD) begin
            instr_d    = NOP_INSTR;
            pcd_d      = '0;
            pcplus4d_d = '0;
            valid_d    = 1'b0;
        end else if (!StallD) begin
            instr_d    = InstrF;
            pcd_d      = pc_q;
            pcplus4d_d = pcplus4_f;
            valid_d    = 1'b1;
            count_d    = count_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pcd_q      <= '0;
            pcplus4d_q <= '0;
            valid_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pcd_q      <= pcd_d;
            pcplus4d_q <= pcplus4d_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
        end
    end

    assign PCF        = pc_q;
    assign InstrD     = instr_q;
    assign PCD        = pcd_q;
    assign PCPlus4D   = pcplus4d_q;
    assign ValidD     = valid_q;
    assign FetchCount = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes hand-computed post-edge state, a monitor pops and compares.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [31:0] id;
        logic [31:0] pcf;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] p4;
        logic        v;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic [31:0] InstrF;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D, FetchCount;
    logic        ValidD;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    always #5 clk = ~clk;

    // Instruction memory: word derived from its address, returned combinationally.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A50F0F;
    endfunction

    assign InstrF = mem(PCF);

    fetch_stage dut (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF), .PCF(PCF),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .FetchCount(FetchCount)
    );

    task automatic chk(input string nm, input logic [31:0] id,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, id, act, req);
        end
    endtask

    // Monitor: after every rising edge, compare against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("PCF",        e.id, PCF,        e.pcf);
            chk("InstrD",     e.id, InstrD,     e.instr);
            chk("PCD",        e.id, PCD,        e.pcd);
            chk("PCPlus4D",   e.id, PCPlus4D,   e.p4);
            chk("ValidD",     e.id, 32'(ValidD), 32'(e.v));
            chk("FetchCount", e.id, FetchCount, e.cnt);
        end
    end

    task automatic step(input logic r, input logic sf, input logic sd, input logic fd,
                        input logic ps, input logic [31:0] tgt,
                        input logic [31:0] pcf, input logic [31:0] instr,
                        input logic [31:0] pcd, input logic [31:0] p4,
                        input logic v, input logic [31:0] cnt);
        exp_t e;
        @(negedge clk);
        rst = r; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
        step_id++;
        e.id = 32'(step_id); e.pcf = pcf; e.instr = instr; e.pcd = pcd;
        e.p4 = p4; e.v = v; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Free-running fetch: D holds the instruction fetched at pcd.
    task automatic run(input logic [31:0] pcf, input logic [31:0] pcd, input logic [31:0] cnt);
        step(0, 0, 0, 0, 0, '0, pcf, mem(pcd), pcd, pcd + 32'd4, 1'b1, cnt);
    endtask

    initial begin
        // Reset state and sequential fetch
        step(1, 0, 0, 0, 0, '0, 32'hBFC00000, NOP, '0, '0, 1'b0, 32'd0);
        step(1, 0, 0, 0, 0, '0, 32'hBFC00000, NOP, '0, '0, 1'b0, 32'd0);
        run(32'hBFC00004, 32'hBFC00000, 32'd1);
        run(32'hBFC00008, 32'hBFC00004, 32'd2);
        run(32'hBFC0000C, 32'hBFC00008, 32'd3);
        run(32'hBFC00010, 32'hBFC0000C, 32'd4);

        // Load-use stall at PCF=BFC00008
        step(1, 0, 0, 0, 0, '0, 32'hBFC00000, NOP, '0, '0, 1'b0, 32'd0);
        run(32'hBFC00004, 32'hBFC00000, 32'd1);
        run(32'hBFC00008, 32'hBFC00004, 32'd2);
        step(0, 1, 1, 0, 0, '0, 32'hBFC00008, mem(32'hBFC00004), 32'hBFC00004, 32'hBFC00008, 1'b1, 32'd2);
        run(32'hBFC0000C, 32'hBFC00008, 32'd3);
        run(32'hBFC00010, 32'hBFC0000C, 32'd4);

        // Taken branch with flush, target low bits dropped
        step(0, 0, 0, 1, 1, 32'hBFC00103, 32'hBFC00100, NOP, '0, '0, 1'b0, 32'd4);
        run(32'hBFC00104, 32'hBFC00100, 32'd5);

        // StallF alone: D reloads the same instruction and still counts
        step(0, 1, 0, 0, 0, '0, 32'hBFC00104, mem(32'hBFC00104), 32'hBFC00104, 32'hBFC00108, 1'b1, 32'd6);
        step(0, 1, 0, 0, 0, '0, 32'hBFC00104, mem(32'hBFC00104), 32'hBFC00104, 32'hBFC00108, 1'b1, 32'd7);
        run(32'hBFC00108, 32'hBFC00104, 32'd8);

        // StallD alone: PC advances, D held
        step(0, 0, 1, 0, 0, '0, 32'hBFC0010C, mem(32'hBFC00104), 32'hBFC00104, 32'hBFC00108, 1'b1, 32'd8);

        // Everything asserted at once
        step(0, 1, 1, 1, 1, 32'h00000040, 32'h00000040, NOP, '0, '0, 1'b0, 32'd8);
        run(32'h00000044, 32'h00000040, 32'd9);

        // Flush overrides StallD
        step(0, 0, 1, 1, 0, '0, 32'h00000048, NOP, '0, '0, 1'b0, 32'd9);

        // PC wrap at the top of the address space
        step(0, 0, 0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFC, NOP, '0, '0, 1'b0, 32'd9);
        step(0, 0, 0, 0, 0, '0, 32'h00000000, mem(32'hFFFFFFFC), 32'hFFFFFFFC, 32'h00000000, 1'b1, 32'd10);
        run(32'h00000004, 32'h00000000, 32'd11);

        // Reset during stall and redirect
        step(1, 1, 1, 0, 1, 32'h00001234, 32'hBFC00000, NOP, '0, '0, 1'b0, 32'd0);
        run(32'hBFC00004, 32'hBFC00000, 32'd1);

        // Redirect without flush: D still takes the wrong-path instruction
        step(0, 0, 0, 0, 1, 32'h00000200, 32'h00000200, mem(32'hBFC00004), 32'hBFC00004, 32'hBFC00008, 1'b1, 32'd2);
        run(32'h00000204, 32'h00000200, 32'd3);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'hBFC00000, PC value loaded on reset.
REQ-002 Parameter: NOP_INSTR, default 32'h00000013 (addi x0,x0,0), bubble instruction inserted into decode.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 StallF  input  1  hold PC (from hazard unit).
REQ-006 StallD  input  1  hold IF/ID register (from hazard unit).
REQ-007 FlushD  input  1  replace IF/ID contents with bubble (from hazard unit).
REQ-008 PCSrcE  input  1  redirect fetch to PCTargetE (branch/jump taken in execute).
REQ-009 PCTargetE  input  32  redirect target computed in execute.
REQ-010 InstrF  input  32  instruction word returned combinationally by instruction memory for PCF.
REQ-011 PCF  output  32  current fetch address to instruction memory.
REQ-012 InstrD  output  32  instruction in decode.
REQ-013 PCD  output  32  PC of InstrD.
REQ-014 PCPlus4D  output  32  PCD + 4.
REQ-015 ValidD  output  1  InstrD is a real fetched instruction (0 = bubble).
REQ-016 FetchCount  output  32  count of instructions accepted into decode.

Function
REQ-017 PCPlus4F = PCF + 4, 32-bit modulo; 32'hFFFFFFFC wraps to 32'h00000000.
REQ-018 Next PC priority: rst -> RESET_PC; else PCSrcE -> {PCTargetE[31:2],2'b00}; else StallF -> hold PCF; else PCPlus4F.
REQ-019 PCSrcE overrides StallF: a taken redirect loads the target even while StallF=1.
REQ-020 PCTargetE[1:0] ignored; PCF[1:0] is always 2'b00.
REQ-021 IF/ID priority each edge: rst -> bubble; else FlushD -> bubble; else StallD -> hold all D outputs; else load InstrF, PCF, PCPlus4F, ValidD=1.
REQ-022 Bubble = InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
REQ-023 FlushD overrides StallD when both asserted in the same cycle.
REQ-024 Latency: instruction at PCF in cycle n appears on InstrD in cycle n+1 when not stalled/flushed.
REQ-025 Redirect: PCSrcE in cycle n -> PCF=target in n+1; with FlushD in n, InstrD holds bubble in n+1 and target instruction in n+2.
REQ-026 FetchCount increments by 1 on each edge where IF/ID loads a real instruction (not rst, not FlushD, not StallD); wraps 32'hFFFFFFFF -> 0.
REQ-027 StallF=1 with StallD=0 and no flush is legal: D reloads the same PCF/InstrF (duplicate) and FetchCount increments.
REQ-028 All outputs registered except PCF, which is the PC register output driven directly.
REQ-029 No combinational path from any input to PCF.

Reset
REQ-030 On rst edge: PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, FetchCount=0.
REQ-031 rst overrides all other inputs, including mid-stall and mid-redirect; first fetch after rst deasserts is at RESET_PC.
REQ-032 Outputs undefined before first rst edge; bench shall assert rst for >=1 cycle first.

Verification
REQ-033 Sequential fetch: rst then 4 free cycles, memory returns PC-derived words -> PCF BFC00000,04,08,0C,10; InstrD lags one cycle; FetchCount=4.
REQ-034 Load-use stall: StallF=StallD=1 for 1 cycle at PCF=BFC00008 -> PCF and InstrD/PCD held one cycle, FetchCount not incremented, then resume at BFC0000C.
REQ-035 Branch: PCSrcE=1, FlushD=1, PCTargetE=BFC00103 -> next PCF=BFC00100, InstrD=00000013, ValidD=0; following cycle PCD=BFC00100, ValidD=1.
REQ-036 Simultaneous: StallF=StallD=FlushD=PCSrcE=1, PCTargetE=00000040 -> PCF=00000040, D bubble, FetchCount unchanged.
REQ-037 Wrap: PCF forced via redirect to FFFFFFFC, free-run -> PCPlus4D=00000000 and PCF=00000000 next; FetchCount preloaded to FFFFFFFF via stimulus run wraps to 0.
REQ-038 Reset mid-operation: rst asserted during active stall with PCSrcE=1 -> PCF=BFC00000, ValidD=0, FetchCount=0 next cycle.
